// File: rtl/thinning_small_core.sv
// Zhang-Suen thinning decision for one 3x3 window, one registered result.
// Define THINNING_SMALL_STEP2_EN to also delete on the second sub-iteration.
module thinning_small_core (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] top,
  input  logic [2:0] center,
  input  logic [2:0] bottom,
  output logic       result
);

  logic       p1, p2, p3, p4;
  logic       p5, p6, p7, p8, p9;
  logic [7:0] nb;
  logic [7:0] rise;
  logic [3:0] cnt_b;
  logic [2:0] cnt_a;
  logic       common;
  logic       step1;
  logic       step2;
  logic       del;
  logic       next_result;

  assign p9 = top[2];
  assign p2 = top[1];
  assign p3 = top[0];
  assign p8 = center[2];
  assign p1 = center[1];
  assign p4 = center[0];
  assign p7 = bottom[2];
  assign p6 = bottom[1];
  assign p5 = bottom[0];

  // nb[7] is P2, walking clockwise down to nb[0] = P9
  assign nb   = {p2, p3, p4, p5, p6, p7, p8, p9};
  assign rise = ~nb & {nb[6:0], nb[7]};

  always_comb begin
    cnt_b = 4'd0;
    cnt_a = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cnt_b = cnt_b + {3'd0, nb[i]};
      cnt_a = cnt_a + {2'd0, rise[i]};
    end
  end

  assign common = p1
                & (cnt_b >= 4'd2)
                & (cnt_b <= 4'd6)
                & (cnt_a == 3'd1);

  assign step1 = common
               & ~(p2 & p4 & p6)
               & ~(p4 & p6 & p8);

`ifdef THINNING_SMALL_STEP2_EN
  assign step2 = common
               & ~(p2 & p4 & p8)
               & ~(p2 & p6 & p8);
  assign del   = step1 | step2;
`else
  assign step2 = 1'b0;
  assign del   = step1 | step2;
`endif

  assign next_result = p1 & ~del;

  always_ff @(posedge clk) begin
    if (rst) begin
      result <= 1'b0;
    end else begin
      result <= next_result;
    end
  end

endmodule

// File: tb/tb_thinning_small_core.sv
// Bench for thinning_small_core: window-level model plus literal vectors.
// Honours THINNING_SMALL_STEP2_EN the same way as the design build.
module tb_thinning_small_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] top = 3'b000;
  logic [2:0] center = 3'b000;
  logic [2:0] bottom = 3'b000;
  logic       result;

  int errors = 0;
  int checks = 0;

  logic exp_q = 1'b0;
  logic have = 1'b0;

`ifdef THINNING_SMALL_STEP2_EN
  localparam bit STEP2 = 1'b1;
`else
  localparam bit STEP2 = 1'b0;
`endif

  thinning_small_core dut (
    .clk    (clk),
    .rst    (rst),
    .top    (top),
    .center (center),
    .bottom (bottom),
    .result (result)
  );

  always #5 clk = ~clk;

  // Neighbour ring in clockwise order starting at P2
  function automatic logic model(input logic [2:0] t,
                                 input logic [2:0] c,
                                 input logic [2:0] b);
    logic ring [8];
    logic pix1;
    int   nb_cnt;
    int   trans;
    logic c1;
    logic c2;
    logic cc;
    pix1    = c[1];
    ring[0] = t[1];
    ring[1] = t[0];
    ring[2] = c[0];
    ring[3] = b[0];
    ring[4] = b[1];
    ring[5] = b[2];
    ring[6] = c[2];
    ring[7] = t[2];
    nb_cnt = 0;
    trans  = 0;
    for (int i = 0; i < 8; i++) begin
      if (ring[i]) nb_cnt++;
      if (!ring[i] && ring[(i + 1) % 8]) trans++;
    end
    cc = pix1 && nb_cnt >= 2 && nb_cnt <= 6 && trans == 1;
    c1 = cc && !(ring[0] && ring[2] && ring[4])
            && !(ring[2] && ring[4] && ring[6]);
    c2 = cc && !(ring[0] && ring[2] && ring[6])
            && !(ring[0] && ring[4] && ring[6]);
    if (STEP2) return pix1 && !(c1 || c2);
    return pix1 && !c1;
  endfunction

  always @(posedge clk) begin
    exp_q <= rst ? 1'b0 : model(top, center, bottom);
    have  <= 1'b1;
  end

  always @(negedge clk) begin
    if (have) begin
      checks++;
      if (result !== exp_q) begin
        errors++;
        $display("FAIL model t=%0t got=%b want=%b", $time, result, exp_q);
      end
    end
  end

  task automatic win(input logic [2:0] t,
                     input logic [2:0] c,
                     input logic [2:0] b,
                     input logic       r,
                     input logic       lit,
                     input string      name);
    top    = t;
    center = c;
    bottom = b;
    rst    = r;
    @(posedge clk);
    #1;
    checks++;
    if (result !== lit) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, result, lit);
    end
  endtask

  initial begin
    win(3'b111, 3'b111, 3'b111, 1'b1, 1'b0, "reset0");
    win(3'b000, 3'b010, 3'b000, 1'b1, 1'b0, "reset1");
    win(3'b111, 3'b011, 3'b011, 1'b0, !STEP2, "b6_step2");
    win(3'b000, 3'b011, 3'b011, 1'b0, 1'b0, "b3_step1");
    win(3'b000, 3'b010, 3'b000, 1'b0, 1'b1, "isolated");
    win(3'b111, 3'b111, 3'b111, 1'b0, 1'b1, "b8");
    win(3'b111, 3'b101, 3'b111, 1'b0, 1'b0, "p1_zero");
    win(3'b010, 3'b010, 3'b000, 1'b0, 1'b1, "b1");
    win(3'b111, 3'b111, 3'b110, 1'b0, 1'b1, "b7");
    win(3'b010, 3'b010, 3'b010, 1'b0, 1'b1, "a2");
    win(3'b110, 3'b110, 3'b000, 1'b0, 1'b0, "nw_corner");
    win(3'b111, 3'b111, 3'b000, 1'b0, 1'b0, "top_edge");
    win(3'b000, 3'b111, 3'b000, 1'b0, 1'b1, "hline_a2");
    win(3'b111, 3'b111, 3'b111, 1'b1, 1'b0, "mid_reset");
    win(3'b000, 3'b010, 3'b000, 1'b0, 1'b1, "resume");
    for (int i = 0; i < 300; i++) begin
      top    = 3'($urandom_range(0, 7));
      center = 3'($urandom_range(0, 7));
      bottom = 3'($urandom_range(0, 7));
      rst    = (i % 97 == 50);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
